// File: rtl/mem_req_arbiter_pkg.sv
// Shared tag codes, size codes and arbiter state encodings for the memory request arbiter.
package mem_req_arbiter_pkg;

  localparam logic       TAG_INST  = 1'b0;
  localparam logic       TAG_DATA  = 1'b1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_HOLD_INST = 2'd1,
    ARB_HOLD_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response channel. The requester side drives the address
// phase; the responder side answers with addr_ok, data_ok and rdata.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic                req;
  logic                wr;
  logic [1:0]          size;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_W-1:0]   rdata;

  // Requester side of a full read/write channel.
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Responder side of a full read/write channel.
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );

  // Responder side of a read-only fetch channel (word reads only).
  modport fetch_slave (
    input  req, addr,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/arb_tag_fifo.sv
// Small in-order tag FIFO (circular buffer). Pushes while full and pops while
// empty are ignored so the pointers can never run past each other.
module arb_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem_q[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data wins
// arbitration, a stalled selection is held until accepted, and responses are
// routed back in order using a tag FIFO.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  mem_req_arbiter_if.fetch_slave inst_bus,
  mem_req_arbiter_if.slave       data_bus,
  mem_req_arbiter_if.master      mem_bus,
  output logic                   resp_err
);

  arb_state_e          state;
  arb_state_e          next_state;
  logic                sel_tag;
  logic                sel_req;
  logic                full;
  logic                empty;
  logic                head;
  logic                accept;
  logic                pop;
  logic                sel_wr;
  logic [1:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic [DATA_W-1:0]   sel_wdata;

  // Choose the requester: data priority when idle, forced while a request is held.
  always_comb begin
    sel_tag = TAG_INST;
    case (state)
      ARB_IDLE:      sel_tag = data_bus.req ? TAG_DATA : TAG_INST;
      ARB_HOLD_INST: sel_tag = TAG_INST;
      ARB_HOLD_DATA: sel_tag = TAG_DATA;
      default:       sel_tag = TAG_INST;
    endcase
    sel_req = (sel_tag == TAG_DATA) ? data_bus.req : inst_bus.req;
  end

  // Mux the address-phase fields; fetches are always plain word reads.
  always_comb begin
    if (sel_tag == TAG_DATA) begin
      sel_wr    = data_bus.wr;
      sel_size  = data_bus.size;
      sel_addr  = data_bus.addr;
      sel_wstrb = data_bus.wstrb;
      sel_wdata = data_bus.wdata;
    end else begin
      sel_wr    = 1'b0;
      sel_size  = SIZE_WORD;
      sel_addr  = inst_bus.addr;
      sel_wstrb = {(DATA_W/8){1'b0}};
      sel_wdata = {DATA_W{1'b0}};
    end
  end

  assign mem_bus.req    = sel_req & ~full;
  assign mem_bus.wr     = sel_wr;
  assign mem_bus.size   = sel_size;
  assign mem_bus.addr   = sel_addr;
  assign mem_bus.wstrb  = sel_wstrb;
  assign mem_bus.wdata  = sel_wdata;

  assign accept            = mem_bus.req & mem_bus.addr_ok;
  assign inst_bus.addr_ok  = accept & (sel_tag == TAG_INST);
  assign data_bus.addr_ok  = accept & (sel_tag == TAG_DATA);

  // A response only pops when a tag is outstanding; it is routed by the head tag.
  assign pop               = mem_bus.data_ok & ~empty;
  assign inst_bus.data_ok  = pop & (head == TAG_INST);
  assign data_bus.data_ok  = pop & (head == TAG_DATA);
  assign inst_bus.rdata    = mem_bus.rdata;
  assign data_bus.rdata    = mem_bus.rdata;

  // Next-state: freeze while full, hold a stalled selection, otherwise idle.
  always_comb begin
    next_state = state;
    if (full) begin
      next_state = state;
    end else if (mem_bus.req && !mem_bus.addr_ok) begin
      next_state = (sel_tag == TAG_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INST;
    end else begin
      next_state = ARB_IDLE;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= next_state;
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!resetn)                       resp_err <= 1'b0;
    else if (mem_bus.data_ok && empty) resp_err <= 1'b1;
    else                               resp_err <= resp_err;
  end

  arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .W     (1)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (sel_tag),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model of the arbitration rules.
module tb_mem_req_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OUT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic resp_err;

  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_bus ();
  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_bus ();
  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  mem_req_arbiter #(.OUTSTANDING(OUT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst_bus (inst_bus),
    .data_bus (data_bus),
    .mem_bus  (mem_bus),
    .resp_err (resp_err)
  );

  // Reference model: outstanding tags (0 = inst, 1 = data), the requester
  // being held (0 none, 1 inst, 2 data) and the sticky error.
  int tagq[$];
  int held  = 0;
  bit m_err = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit rn, input bit ireq, input logic [31:0] iaddr,
                      input bit dreq, input bit dwr, input logic [1:0] dsize,
                      input logic [31:0] daddr, input logic [3:0] dstrb,
                      input logic [31:0] dwdata, input bit mok, input bit mdok,
                      input logic [31:0] mrdata, output bit iacc, output bit dacc);
    bit full, sreq, e_mreq, acc, has, e_idok, e_ddok;
    int sel;
    @(negedge clk);
    resetn         = rn;
    inst_bus.req   = ireq;
    inst_bus.addr  = iaddr;
    data_bus.req   = dreq;
    data_bus.wr    = dwr;
    data_bus.size  = dsize;
    data_bus.addr  = daddr;
    data_bus.wstrb = dstrb;
    data_bus.wdata = dwdata;
    mem_bus.addr_ok = mok;
    mem_bus.data_ok = mdok;
    mem_bus.rdata   = mrdata;
    #1;
    full = (tagq.size() >= OUT);
    if (held != 0)  sel = held;
    else if (dreq)  sel = 2;
    else if (ireq)  sel = 1;
    else            sel = 0;
    sreq   = (sel == 2) ? dreq : ((sel == 1) ? ireq : 1'b0);
    e_mreq = sreq && !full;
    acc    = e_mreq && mok;
    has    = (tagq.size() > 0);
    e_idok = mdok && has && (tagq[0] == 0);
    e_ddok = mdok && has && (tagq[0] == 1);
    check_eq("mem_req",      64'(mem_bus.req),       64'(e_mreq));
    check_eq("inst_addr_ok", 64'(inst_bus.addr_ok),  64'(acc && sel == 1));
    check_eq("data_addr_ok", 64'(data_bus.addr_ok),  64'(acc && sel == 2));
    check_eq("inst_data_ok", 64'(inst_bus.data_ok),  64'(e_idok));
    check_eq("data_data_ok", 64'(data_bus.data_ok),  64'(e_ddok));
    check_eq("resp_err",     64'(resp_err),          64'(m_err));
    if (e_mreq) begin
      check_eq("mem_addr",  64'(mem_bus.addr),  64'((sel == 2) ? daddr : iaddr));
      check_eq("mem_wr",    64'(mem_bus.wr),    64'((sel == 2) ? dwr : 1'b0));
      check_eq("mem_size",  64'(mem_bus.size),  64'((sel == 2) ? dsize : 2'd2));
      check_eq("mem_wstrb", 64'(mem_bus.wstrb), 64'((sel == 2) ? dstrb : 4'd0));
      check_eq("mem_wdata", 64'(mem_bus.wdata), 64'((sel == 2) ? dwdata : 32'd0));
    end
    if (e_idok) check_eq("inst_rdata", 64'(inst_bus.rdata), 64'(mrdata));
    if (e_ddok) check_eq("data_rdata", 64'(data_bus.rdata), 64'(mrdata));
    iacc = acc && (sel == 1);
    dacc = acc && (sel == 2);
    @(posedge clk);
    if (mdok) begin
      if (has) void'(tagq.pop_front());
      else     m_err = 1'b1;
    end
    if (acc) tagq.push_back((sel == 2) ? 1 : 0);
    if (!full) held = (e_mreq && !mok) ? sel : 0;
    if (!rn) begin
      tagq.delete();
      held  = 0;
      m_err = 1'b0;
    end
  endtask

  // Shorthands for the directed scenarios (loads only, fixed addresses).
  task automatic cyc(input bit ireq, input bit dreq, input bit mok, input bit mdok,
                     input logic [31:0] mrdata);
    bit ia, da;
    step(1'b1, ireq, 32'h1C00_0000, dreq, 1'b0, 2'd2, 32'h1C00_1000, 4'h0, 32'h0,
         mok, mdok, mrdata, ia, da);
  endtask

  initial begin
    bit ip, dp, ia, da, dwr, mok, mdok, rn;
    logic [31:0] iaddr, daddr, dwdata;
    logic [1:0]  dsize;
    logic [3:0]  dstrb;
    int slow;

    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
    inst_bus.addr = '0; inst_bus.wstrb = '0; inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd0;
    data_bus.addr = '0; data_bus.wstrb = '0; data_bus.wdata = '0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: everything quiet.
    cyc(0, 0, 0, 0, 32'h0);

    // Lone fetch, response two cycles later.
    cyc(1, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0280_0C0C);

    // Both request: data first, then inst; responses routed D then I.
    cyc(1, 1, 1, 0, 32'h0);
    cyc(1, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hDDDD_0001);
    cyc(0, 0, 0, 1, 32'h1111_0002);

    // Stalled fetch is held while a data request arrives.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0);
    cyc(0, 1, 1, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hA000_0001);
    cyc(0, 0, 0, 1, 32'hA000_0002);

    // Full: no acceptance, no bypass in the pop cycle, accept the cycle after.
    cyc(1, 0, 1, 0, 32'h0);
    cyc(0, 1, 1, 0, 32'h0);
    cyc(1, 0, 1, 0, 32'h0);
    cyc(1, 0, 1, 1, 32'hB000_0001);
    cyc(1, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hB000_0002);
    cyc(0, 0, 0, 1, 32'hB000_0003);

    // Push and pop together, then the remaining tag routes to inst.
    cyc(0, 1, 1, 0, 32'h0);
    cyc(1, 0, 1, 1, 32'hC000_0001);
    cyc(0, 0, 0, 1, 32'hC000_0002);

    // Response with nothing outstanding: sticky error, cleared by reset.
    cyc(0, 0, 0, 1, 32'hE000_0000);
    cyc(0, 0, 0, 0, 32'h0);
    step(1'b0, 0, 32'h0, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, ia, da);
    cyc(0, 0, 0, 0, 32'h0);

    // Random traffic with requesters that hold req until accepted.
    ip = 1'b0; dp = 1'b0;
    iaddr = '0; daddr = '0; dwr = 1'b0; dsize = 2'd2; dstrb = '0; dwdata = '0;
    for (int n = 0; n < 800; n++) begin
      slow = (n / 100) % 2;
      if (!ip && ($urandom % 3 == 0)) begin
        ip = 1'b1;
        iaddr = {$urandom} & 32'hFFFF_FFFC;
      end
      if (!dp && ($urandom % 3 == 0)) begin
        dp     = 1'b1;
        dwr    = 1'($urandom % 2);
        dsize  = 2'($urandom % 3);
        daddr  = $urandom;
        dstrb  = 4'($urandom);
        dwdata = $urandom;
      end
      mok  = 1'($urandom % 2);
      mdok = (tagq.size() > 0) && ($urandom % (slow ? 5 : 2) == 0);
      rn   = !(n == 400);
      if (!rn) begin
        ip = 1'b0;
        dp = 1'b0;
        mdok = 1'b0;
      end
      step(rn, ip, iaddr, dp, dwr, dsize, daddr, dstrb, dwdata, mok, mdok, $urandom, ia, da);
      if (ia) ip = 1'b0;
      if (da) dp = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX/MEM stage).
- Arbitrates address-phase requests with data priority.
- Holds the selection stable until the slave accepts.
- Tracks outstanding transactions in an in-order tag FIFO, so each data_ok/rdata is routed back to the requester that issued it.
- Sits between the pipeline stages and the AXI bridge / unified SRAM.

Parameters:
- OUTSTANDING, 2, max in-flight accepted-but-unanswered requests; power of two, >= 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width = DATA_W/8.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req  in  1  IF request valid; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  IF request accepted this cycle
- inst_data_ok  out  1  IF read data valid this cycle
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request valid; held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  data address
- data_wstrb  in  DATA_W/8  byte strobes
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data / store ack valid this cycle
- data_rdata  out  DATA_W  load data
- mem_req  out  1  downstream request valid
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_addr  out  ADDR_W  downstream address
- mem_wstrb  out  DATA_W/8  downstream strobes
- mem_wdata  out  DATA_W  downstream write data
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid (in order)
- mem_rdata  in  DATA_W  downstream response data
- resp_err  out  1  sticky: mem_data_ok seen with no outstanding tag

Behaviour:
- Reset (resetn=0 at posedge):
  - Tag FIFO emptied, count=0.
  - Arbiter state to IDLE.
  - resp_err cleared.
  - During and after reset, all *_ok outputs and mem_req are 0 until a requester drives req.
- Arbiter FSM states: IDLE, HOLD_INST, HOLD_DATA.
- IDLE:
  - Select data if data_req, else inst if inst_req.
  - Selection is combinational; mem_req = selected req & ~full.
- Acceptance:
  - A request is accepted when mem_req & mem_addr_ok; the selected requester gets *_addr_ok=1 the same cycle (zero latency).
  - On acceptance: push tag (0=inst, 1=data) into the FIFO; state stays/returns IDLE.
- Hold:
  - If mem_req=1 and mem_addr_ok=0, go to HOLD_x for the selected x.
  - In HOLD_x, the selection is forced to x (no priority switch) until accepted; then go to IDLE.
  - A newly arriving data_req does not preempt a held inst request.
- Field muxing:
  - The mem_* address fields are muxed from the selected requester.
  - For inst: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
- Full:
  - full = (count == OUTSTANDING), based on registered count only; no same-cycle pop bypass.
  - When full: mem_req=0, both addr_ok=0, FSM state unchanged.
- Response:
  - mem_data_ok pops the FIFO head.
  - head=0 gives inst_data_ok=1; head=1 gives data_data_ok=1, same cycle (combinational).
  - mem_rdata is driven to both inst_rdata and data_rdata unconditionally.
- Simultaneous push and pop: both happen, count unchanged, FIFO order preserved.
- Empty + mem_data_ok:
  - Both data_ok=0, no pop.
  - resp_err set and held until reset.
- FIFO: circular buffer with rd/wr pointers of log2(OUTSTANDING) bits wrapping modulo OUTSTANDING; count is log2(OUTSTANDING)+1 bits.
- Writes produce a data_ok response like loads; they occupy a tag identically.
- Reset mid-transaction: in-flight tags are discarded. The system resets the downstream memory together with the arbiter.

Decomposition:
- Shared header mycpu.h: `TAG_INST=1'b0`, `TAG_DATA=1'b1`, `SIZE_WORD=2'd2`, and the arbiter state encodings.
- One natural sub-module: arb_tag_fifo (width 1, depth OUTSTANDING, push/pop/full/empty/head), reusable for the AXI bridge ID tracking.

Test Plan:
- Only inst_req=1, addr 0x1C000000; mem_addr_ok=1 same cycle; mem_data_ok 2 cycles later with rdata 0x02800C0C.
  -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata 0x02800C0C; data_data_ok=0.
- inst_req and data_req (load, addr 0x1C001000) both asserted, mem_addr_ok=1.
  -> data accepted first (data_addr_ok=1, inst_addr_ok=0); inst accepted next cycle.
  -> Responses D then I are routed to data then inst, in that order.
- inst_req with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1.
  -> mem_addr stays the inst address for all 3 cycles (HOLD_INST).
  -> Inst is accepted when mem_addr_ok=1; data is accepted afterwards.
- OUTSTANDING=2: accept 2 requests with no mem_data_ok.
  -> Cycle 3: mem_req=0, both addr_ok=0.
  -> In the cycle mem_data_ok=1, mem_req stays 0 (no bypass); the next cycle a new request is accepted.
- Same cycle: push (accept inst) and pop (data response for the head tag).
  -> count unchanged (1); the following response routes to inst.
- mem_data_ok=1 with empty FIFO.
  -> No data_ok asserted; resp_err=1 and stays 1; resetn=0 for one posedge clears it to 0.
